// File: rtl/alu_result_serializer_if.sv
// Bus bundle for alu_result_serializer: ALU result stream in, 16-bit word stream out.
// master = producer/consumer side (testbench or neighbours); slave = the serializer itself.
interface alu_result_serializer_if #(
   parameter int unsigned RES_W = 48,
   parameter int unsigned OUT_W = 16
);
   logic             in_valid;
   logic             in_error;
   logic [RES_W-1:0] in_result;
   logic             out_valid;
   logic             out_ready;
   logic [OUT_W-1:0] out_data;
   logic             out_first;
   logic             out_last;

   modport master (
      output in_valid, in_error, in_result, out_ready,
      input  out_valid, out_data, out_first, out_last
   );

   modport slave (
      input  in_valid, in_error, in_result, out_ready,
      output out_valid, out_data, out_first, out_last
   );
endinterface

// File: rtl/alu_result_serializer.sv
// Buffers good ALU results in a FIFO and drains each as three OUT_W words, LSW first.
// Optional: define ALU_SER_ERR_COUNT_EN to build the saturating error-drop counter.
module alu_result_serializer #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned RES_W = 48,
   parameter int unsigned OUT_W = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   alu_result_serializer_if.slave       bus,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         overflow,
   output logic [7:0]                   err_count
);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam int unsigned PTR_W = $clog2(DEPTH);

   typedef enum logic [1:0] {StIdle, StW0, StW1, StW2} state_e;

   state_e           state_q, state_d;
   logic [RES_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q, count_d;
   logic [RES_W-1:0] res_q, res_d;
   logic [OUT_W-1:0] data_q, data_d;
   logic             valid_q, valid_d;
   logic             first_q, first_d;
   logic             last_q, last_d;
   logic             overflow_q, overflow_d;
   logic [RES_W-1:0] head;
   logic             good, handshake, pop, push;

   assign head      = mem_q[rd_ptr_q];
   assign full      = (count_q == CNT_W'(DEPTH));
   assign empty     = (count_q == '0);
   assign good      = bus.in_valid && !bus.in_error;
   assign handshake = valid_q && bus.out_ready;
   // A full FIFO still accepts when the head leaves on the same edge.
   assign push      = good && (!full || pop);

   assign count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
   assign overflow_d = overflow_q | (good && full && !pop);

   always_comb begin
      state_d = state_q;
      res_d   = res_q;
      data_d  = data_q;
      valid_d = valid_q;
      first_d = first_q;
      last_d  = last_q;
      pop     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (count_q != '0) begin
               pop     = 1'b1;
               res_d   = head;
               data_d  = head[OUT_W-1:0];
               valid_d = 1'b1;
               first_d = 1'b1;
               state_d = StW0;
            end
         end
         StW0: begin
            if (handshake) begin
               data_d  = res_q[2*OUT_W-1:OUT_W];
               first_d = 1'b0;
               state_d = StW1;
            end
         end
         StW1: begin
            if (handshake) begin
               data_d  = res_q[3*OUT_W-1:2*OUT_W];
               last_d  = 1'b1;
               state_d = StW2;
            end
         end
         StW2: begin
            if (handshake) begin
               last_d = 1'b0;
               if (count_q != '0) begin
                  // Chain straight into the next result without an idle cycle.
                  pop     = 1'b1;
                  res_d   = head;
                  data_d  = head[OUT_W-1:0];
                  first_d = 1'b1;
                  state_d = StW0;
               end else begin
                  valid_d = 1'b0;
                  state_d = StIdle;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         res_q      <= '0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         first_q    <= 1'b0;
         last_q     <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         res_q      <= res_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
         first_q    <= first_d;
         last_q     <= last_d;
         overflow_q <= overflow_d;
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
   end

   // Storage needs no reset: pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= bus.in_result;
   end

`ifdef ALU_SER_ERR_COUNT_EN
   logic [7:0] err_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         err_cnt_q <= 8'd0;
      end else if (bus.in_valid && bus.in_error && (err_cnt_q != 8'hff)) begin
         err_cnt_q <= err_cnt_q + 8'd1;
      end
   end

   assign err_count = err_cnt_q;
`else
   assign err_count = 8'd0;
`endif

   assign bus.out_valid = valid_q;
   assign bus.out_data  = data_q;
   assign bus.out_first = first_q;
   assign bus.out_last  = last_q;
   assign count         = count_q;
   assign overflow      = overflow_q;
endmodule

// File: tb/tb_alu_result_serializer.sv
// Self-checking bench for alu_result_serializer: directed scenarios plus a randomized run
// against a queue-based reference model of the buffered result stream.
module tb_alu_result_serializer;
   localparam int unsigned DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       full, empty, overflow;
   logic [2:0] count;
   logic [7:0] err_count;
   int         checks = 0;
   int         errors = 0;

   alu_result_serializer_if #(.RES_W(48), .OUT_W(16)) bus ();

   alu_result_serializer #(.DEPTH(DEPTH), .RES_W(48), .OUT_W(16)) dut (
      .clk(clk), .rst(rst), .bus(bus), .full(full), .empty(empty),
      .count(count), .overflow(overflow), .err_count(err_count)
   );

   always #5 clk = ~clk;

   // Reference model: a queue of buffered results plus the result currently on the bus.
   logic [47:0] m_q [$];
   logic [47:0] acc_q [$];
   logic [17:0] del_q [$];
   bit          m_busy = 1'b0;
   int          m_widx = 0;
   logic [47:0] m_cur = '0;
   logic [15:0] m_data = '0;
   bit          m_ovf = 1'b0;
   int          m_err = 0;

   always @(posedge clk) begin : model
      bit good, hs, pop, acc;
      if (rst) begin
         m_busy = 1'b0; m_widx = 0; m_data = '0; m_ovf = 1'b0; m_err = 0;
         m_q.delete();
      end else begin
         good = bus.in_valid && !bus.in_error;
         hs   = m_busy && bus.out_ready;
         pop  = (m_q.size() > 0) && (!m_busy || (hs && m_widx == 2));
         acc  = good && ((m_q.size() < DEPTH) || pop);
         if (bus.in_valid && bus.in_error && m_err < 255) m_err++;
         if (good && !acc) m_ovf = 1'b1;
         if (hs && m_widx < 2) begin
            m_widx++;
            m_data = m_cur[m_widx*16 +: 16];
         end else if (pop) begin
            m_cur  = m_q.pop_front();
            m_busy = 1'b1;
            m_widx = 0;
            m_data = m_cur[15:0];
         end else if (hs) begin
            m_busy = 1'b0;
         end
         if (acc) begin
            m_q.push_back(bus.in_result);
            acc_q.push_back(bus.in_result);
         end
      end
   end

   // Words actually transferred: ready is stable at the falling edge.
   always @(negedge clk) begin
      if (!rst && bus.out_valid && bus.out_ready)
         del_q.push_back({bus.out_first, bus.out_last, bus.out_data});
   end

   function automatic logic [24:0] model_view();
      int unsigned n = m_q.size();
      return {m_busy, m_busy && (m_widx == 0), m_busy && (m_widx == 2), m_data, 3'(n),
              n == DEPTH, n == 0, m_ovf};
   endfunction

   function automatic logic [24:0] dut_view();
      return {bus.out_valid, bus.out_first, bus.out_last, bus.out_data, count, full, empty,
              overflow};
   endfunction

   function automatic logic [7:0] model_err();
`ifdef ALU_SER_ERR_COUNT_EN
      return 8'(m_err);
`else
      return 8'd0;
`endif
   endfunction

   function automatic logic [17:0] exp_word(input logic [47:0] r, input int j);
      return {j == 0, j == 2, r[16*j +: 16]};
   endfunction

   function automatic logic [47:0] rand_res();
      return {16'($urandom), 32'($urandom)};
   endfunction

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.in_valid = 1'b0; bus.in_error = 1'b0; bus.out_ready = 1'b0;
      next();
      next();
      rst = 1'b0;
      acc_q.delete();
      del_q.delete();
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         bus.in_valid  = 1'($urandom);
         bus.in_error  = 1'($urandom);
         bus.out_ready = 1'($urandom);
         bus.in_result = rand_res();
         next();
         checks++;
         if (dut_view() !== {3'b000, 16'h0, 3'd0, 1'b0, 1'b1, 1'b0} || err_count !== 8'd0) begin
            errors++;
            $display("FAIL reset[%0d]: got %h err %0d want %h err 0", i, dut_view(), err_count,
                     {3'b000, 16'h0, 3'd0, 1'b0, 1'b1, 1'b0});
         end
      end
      rst = 1'b0;
      bus.in_valid = 1'b0;
   endtask

   task automatic test_single();
      logic [6:0]  exp_ctl [5];
      logic [15:0] exp_dat [5];
      logic [6:0]  got;
      logic [47:0] r = 48'h0003_0002_0001;
      // {valid, first, last, count, empty} after each edge
      exp_ctl = '{7'b000_001_0, 7'b110_000_1, 7'b100_000_1, 7'b101_000_1, 7'b000_000_1};
      exp_dat = '{16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0000};
      do_reset();
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_error  = 1'b0;
      bus.in_result = r;
      for (int i = 0; i < 5; i++) begin
         next();
         bus.in_valid = 1'b0;
         got = {bus.out_valid, bus.out_first, bus.out_last, count, empty};
         checks++;
         if (got !== exp_ctl[i] || (exp_ctl[i][6] && bus.out_data !== exp_dat[i])) begin
            errors++;
            $display("FAIL single[%0d]: ctl %b data %h want ctl %b data %h", i, got,
                     bus.out_data, exp_ctl[i], exp_dat[i]);
         end
      end
      checks++;
      if (del_q.size() != 3) begin
         errors++;
         $display("FAIL single_words: got %0d words want 3", del_q.size());
      end
      for (int j = 0; j < 3 && j < del_q.size(); j++) begin
         checks++;
         if (del_q[j] !== exp_word(r, j)) begin
            errors++;
            $display("FAIL single_word[%0d]: got %h want %h", j, del_q[j], exp_word(r, j));
         end
      end
   endtask

   task automatic test_backpressure();
      bit          pat [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      logic [18:0] prev;
      bit          prev_rdy;
      logic [47:0] r = 48'h0003_0002_0001;
      int          k;
      do_reset();
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_result = r;
      next();
      bus.in_valid = 1'b0;
      for (k = 0; k < 4 && !bus.out_valid; k++) next();
      checks++;
      if (!bus.out_valid) begin
         errors++;
         $display("FAIL bp_wait: out_valid %b want 1 within 4 cycles", bus.out_valid);
      end
      for (int i = 0; i < 8; i++) begin
         prev     = {bus.out_valid, bus.out_first, bus.out_last, bus.out_data};
         prev_rdy = (i < 5) ? pat[i] : 1'b1;
         bus.out_ready = prev_rdy;
         next();
         if (prev[18] && !prev_rdy) begin
            checks++;
            if ({bus.out_valid, bus.out_first, bus.out_last, bus.out_data} !== prev) begin
               errors++;
               $display("FAIL bp_hold[%0d]: got %h want %h", i,
                        {bus.out_valid, bus.out_first, bus.out_last, bus.out_data}, prev);
            end
         end
         checks++;
         if (dut_view() !== model_view()) begin
            errors++;
            $display("FAIL bp_model[%0d]: got %h want %h", i, dut_view(), model_view());
         end
      end
      checks++;
      if (del_q.size() != 3 || bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_once: got %0d words valid %b want 3 words valid 0", del_q.size(),
                  bus.out_valid);
      end
      for (int j = 0; j < 3 && j < del_q.size(); j++) begin
         checks++;
         if (del_q[j] !== exp_word(r, j)) begin
            errors++;
            $display("FAIL bp_word[%0d]: got %h want %h", j, del_q[j], exp_word(r, j));
         end
      end
   endtask

   task automatic test_overflow();
      logic [47:0] r [6];
      do_reset();
      bus.out_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         r[i] = rand_res();
         bus.in_valid  = 1'b1;
         bus.in_error  = 1'b0;
         bus.in_result = r[i];
         next();
      end
      bus.in_valid = 1'b0;
      checks++;
      if ({full, count, overflow, bus.out_valid, bus.out_first} !== {1'b1, 3'd4, 1'b1, 2'b11}) begin
         errors++;
         $display("FAIL ovf_state: full %b count %0d ovf %b valid %b first %b want 1 4 1 1 1",
                  full, count, overflow, bus.out_valid, bus.out_first);
      end
      bus.out_ready = 1'b1;
      for (int i = 0; i < 15; i++) begin
         checks++;
         if (bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL ovf_bubble[%0d]: out_valid %b want 1", i, bus.out_valid);
         end
         next();
      end
      checks++;
      if (bus.out_valid !== 1'b0 || del_q.size() != 15 || overflow !== 1'b1) begin
         errors++;
         $display("FAIL ovf_drain: valid %b words %0d ovf %b want 0 15 1", bus.out_valid,
                  del_q.size(), overflow);
      end
      for (int i = 0; i < 15 && i < del_q.size(); i++) begin
         checks++;
         if (del_q[i] !== exp_word(r[i/3], i%3)) begin
            errors++;
            $display("FAIL ovf_word[%0d]: got %h want %h", i, del_q[i], exp_word(r[i/3], i%3));
         end
      end
   endtask

   task automatic test_error_drop();
      logic [47:0] r = rand_res();
      do_reset();
      bus.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus.in_valid  = 1'b1;
         bus.in_error  = 1'b1;
         bus.in_result = rand_res();
         next();
         checks++;
         if (bus.out_valid !== 1'b0 || count !== 3'd0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL err_drop[%0d]: valid %b count %0d empty %b want 0 0 1", i,
                     bus.out_valid, count, empty);
         end
      end
      bus.in_error = 1'b0;
      checks++;
`ifdef ALU_SER_ERR_COUNT_EN
      if (err_count !== 8'd3) begin
         errors++;
         $display("FAIL err_count: got %0d want 3", err_count);
      end
`else
      if (err_count !== 8'd0) begin
         errors++;
         $display("FAIL err_count: got %0d want 0", err_count);
      end
`endif
      bus.in_result = r;
      next();
      bus.in_valid = 1'b0;
      for (int i = 0; i < 6; i++) next();
      checks++;
      if (del_q.size() != 3) begin
         errors++;
         $display("FAIL err_good: got %0d words want 3", del_q.size());
      end
      for (int j = 0; j < 3 && j < del_q.size(); j++) begin
         checks++;
         if (del_q[j] !== exp_word(r, j)) begin
            errors++;
            $display("FAIL err_word[%0d]: got %h want %h", j, del_q[j], exp_word(r, j));
         end
      end
   endtask

   task automatic test_full_pop();
      logic [47:0] r [6];
      do_reset();
      bus.out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         r[i] = rand_res();
         bus.in_valid  = 1'b1;
         bus.in_error  = 1'b0;
         bus.in_result = r[i];
         next();
      end
      bus.in_valid = 1'b0;
      checks++;
      if ({full, count, overflow} !== {1'b1, 3'd4, 1'b0}) begin
         errors++;
         $display("FAIL fp_fill: full %b count %0d ovf %b want 1 4 0", full, count, overflow);
      end
      bus.out_ready = 1'b1;
      next();
      next();
      r[5] = rand_res();
      bus.in_valid  = 1'b1;
      bus.in_result = r[5];
      next();
      bus.in_valid = 1'b0;
      checks++;
      if ({full, count, overflow, bus.out_first} !== {1'b1, 3'd4, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL fp_pushpop: full %b count %0d ovf %b first %b want 1 4 0 1", full,
                  count, overflow, bus.out_first);
      end
      for (int i = 0; i < 20; i++) next();
      checks++;
      if (del_q.size() != 18 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL fp_drain: got %0d words ovf %b want 18 0", del_q.size(), overflow);
      end
      for (int i = 0; i < 18 && i < del_q.size(); i++) begin
         checks++;
         if (del_q[i] !== exp_word(r[i/3], i%3)) begin
            errors++;
            $display("FAIL fp_word[%0d]: got %h want %h", i, del_q[i], exp_word(r[i/3], i%3));
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [47:0] r0;
      int          n0;
      do_reset();
      bus.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bus.in_valid  = 1'b1;
         bus.in_error  = 1'b0;
         bus.in_result = rand_res();
         if (i == 0) r0 = bus.in_result;
         next();
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      next();
      checks++;
      if (count !== 3'd2 || bus.out_data !== r0[31:16]) begin
         errors++;
         $display("FAIL rm_setup: count %0d data %h want 2 %h", count, bus.out_data, r0[31:16]);
      end
      rst = 1'b1;
      next();
      rst = 1'b0;
      checks++;
      if ({bus.out_valid, count, empty, overflow} !== {1'b0, 3'd0, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL rm_reset: valid %b count %0d empty %b ovf %b want 0 0 1 0",
                  bus.out_valid, count, empty, overflow);
      end
      n0 = del_q.size();
      for (int i = 0; i < 10; i++) begin
         next();
         checks++;
         if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rm_stale[%0d]: out_valid %b want 0", i, bus.out_valid);
         end
      end
      checks++;
      if (del_q.size() != n0) begin
         errors++;
         $display("FAIL rm_words: got %0d words want %0d", del_q.size(), n0);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 400; i++) begin
         bus.in_valid  = ($urandom_range(0, 9) < 7);
         bus.in_error  = ($urandom_range(0, 9) < 2);
         bus.in_result = rand_res();
         bus.out_ready = ($urandom_range(0, 9) < 5);
         next();
         checks++;
         if (dut_view() !== model_view() || err_count !== model_err()) begin
            errors++;
            $display("FAIL rand[%0d]: got %h err %0d want %h err %0d", i, dut_view(),
                     err_count, model_view(), model_err());
         end
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 24; i++) next();
      checks++;
      if (del_q.size() != 3 * acc_q.size()) begin
         errors++;
         $display("FAIL rand_count: got %0d words want %0d", del_q.size(), 3 * acc_q.size());
      end
      for (int i = 0; i < del_q.size() && i < 3 * acc_q.size(); i++) begin
         checks++;
         if (del_q[i] !== exp_word(acc_q[i/3], i%3)) begin
            errors++;
            $display("FAIL rand_word[%0d]: got %h want %h", i, del_q[i],
                     exp_word(acc_q[i/3], i%3));
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_error  = 1'b0;
      bus.in_result = '0;
      bus.out_ready = 1'b0;
      test_reset();
      test_single();
      test_backpressure();
      test_overflow();
      test_error_drop();
      test_full_pop();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/alu_result_serializer.md
Name: alu_result_serializer

Overview:
- Downstream stage of the complex ALU; consumes its valid/error/48-bit result stream.
- Buffers accepted results in a small FIFO, then drains each one as three 16-bit words over a ready/valid bus. The bus feeds narrow logging or host logic.
- Drops error-flagged results and counts them. Flags FIFO overflow.

Parameters:
- DEPTH, 4, FIFO entries; must be a power of two, ≥2.
- RES_W, 48, input result width; fixed at 3*OUT_W.
- OUT_W, 16, output word width.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  ALU result strobe; one result per cycle while high.
- in_error  in  1  ALU error flag, qualified by in_valid.
- in_result  in  RES_W  ALU result, qualified by in_valid.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts the word when out_valid && out_ready.
- out_data  out  OUT_W  current word.
- out_first  out  1  current word is word 0 of a result.
- out_last  out  1  current word is word 2 of a result.
- full  out  1  FIFO holds DEPTH entries.
- empty  out  1  FIFO holds 0 entries.
- count  out  $clog2(DEPTH+1)  FIFO occupancy; excludes the result being serialized.
- overflow  out  1  sticky; set when a good result is dropped because no slot is free.
- err_count  out  8  error-drop counter (see Optional Feature).

Behaviour:
- Reset (rst=1 at a clock edge):
  - out_valid, out_first, out_last, overflow = 0; out_data = 0; count = 0; empty = 1; full = 0; err_count = 0.
  - FSM goes to IDLE; FIFO pointers clear.
  - Reset mid-transfer abandons the current result and all FIFO contents.
- Push:
  - Occurs when in_valid && !in_error && (!full || pop_this_cycle).
  - in_valid && in_error: result discarded, no FIFO change.
  - in_valid && !in_error && full && !pop: result discarded, overflow <= 1 and held until rst.
- FSM states:
  - IDLE: if count>0, pop FIFO head into the 48-bit shift register, out_data <= head[15:0], out_valid <= 1, out_first <= 1, go to W0. Otherwise stay.
  - W0: on handshake, out_data <= bits[31:16], out_first <= 0, go to W1.
  - W1: on handshake, out_data <= bits[47:32], out_last <= 1, go to W2.
  - W2: on handshake, out_last <= 0.
    - If count>0: pop the next head, load word 0 with out_first <= 1, stay valid, go to W0. Back-to-back results have no bubble.
    - Else: out_valid <= 0, go to IDLE.
  - Without a handshake, every state holds out_data/out_valid/out_first/out_last stable.
- Word order: least-significant word first.
- Latency: result sampled at edge k → count=1 after k → out_valid=1 after edge k+1 (2 cycles) when IDLE with an empty FIFO.
- Total storage is DEPTH+1 results: DEPTH in the FIFO plus one in the shift register.
- Simultaneous push and pop at full: both happen, count unchanged, no overflow.
- Simultaneous push and pop at empty is impossible, since a pop needs count>0. Push at count=0 in IDLE is loaded on the next edge.
- Pointers wrap modulo DEPTH. full = (count==DEPTH), empty = (count==0); both registered-consistent with count.

Optional Feature:
- Macro: ALU_SER_ERR_COUNT_EN.
- Defined: err_count increments on each cycle with in_valid && in_error; it saturates at 255 and clears only on rst.
- Undefined: err_count is tied to 0 and no counter logic is built.

Test Plan:
1. Single result: rst, then in_valid=1 for one cycle with in_result=0x0003_0002_0001, out_ready=1. Required:
   - out_valid 2 cycles later.
   - words 0x0001 (first=1), 0x0002, 0x0003 (last=1) on consecutive cycles.
   - then out_valid=0, empty=1.
2. Backpressure: same result, out_ready toggling 1,0,0,1,1. Required: each word holds stable while ready=0; the sequence 0001/0002/0003 is delivered exactly once.
3. Overflow: out_ready=0, six back-to-back good results R0..R5. Required:
   - R0 goes to the shift register; R1..R4 fill the FIFO (full=1, count=4).
   - R5 is dropped, overflow=1.
   - With out_ready=1 thereafter, 15 words are output for R0..R4 in order, with no bubbles.
4. Error drop: in_valid=1, in_error=1 three times. Required:
   - No out_valid; count stays 0.
   - err_count=3 with ALU_SER_ERR_COUNT_EN, 0 without.
   - A subsequent good result serializes normally.
5. Full plus pop: hold FIFO full with out_ready=0, then raise out_ready. Required: a push coincident with the W2→W0 pop is accepted, count stays 4, overflow stays 0.
6. Reset mid-transfer: assert rst during word W1 with 2 entries queued. Required: the next cycle shows out_valid=0, count=0, empty=1, overflow=0, and no stale words appear afterwards.
